// File: rtl/udiv_pkg.sv
// ============================================================================
//  Module   : udiv_pkg
//  Purpose  : Shared declarations for the sequential unsigned divider:
//             FSM state encoding, counter-width helpers and the all-ones
//             constant used as the divide-by-zero quotient.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package udiv_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the bit counter for the default 8-bit divider.
  localparam int UDIV_DEFAULT_WIDTH = 8;
  localparam int UDIV_CNT_W         = $clog2(UDIV_DEFAULT_WIDTH);

  // Counter width for an arbitrary operand width. The counter only has to
  // hold WIDTH-1, so $clog2(WIDTH) bits are enough; never below 1 bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  // All-ones pattern of the given width, right-aligned in 32 bits.
  function automatic logic [31:0] all_ones(input int w);
    if (w >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage : udiv_pkg

`default_nettype wire

// File: rtl/udiv_step.sv
// ============================================================================
//  Module   : udiv_step
//  Purpose  : One combinational restoring-division step. Shifts the next
//             dividend bit (MSB of q) into the partial remainder, compares
//             against the divisor and conditionally subtracts.
//  Ports    : r      in  WIDTH  partial remainder (always < b)
//             q      in  WIDTH  quotient/dividend shift register
//             b      in  WIDTH  divisor (non-zero)
//             r_next out WIDTH  updated partial remainder
//             q_next out WIDTH  q shifted left with the new quotient bit
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module udiv_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] diff;

  assign trial = {r, q[WIDTH-1]};
  assign ge    = (trial >= {1'b0, b});

  // Because r < b on entry, trial < 2*b, so whenever ge is set the true
  // difference is < b and fits in WIDTH bits: the low WIDTH bits of the
  // wrap-around subtraction are exact.
  assign diff   = trial[WIDTH-1:0] - b;

  assign r_next = ge ? diff : trial[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], ge};

endmodule : udiv_step

`default_nettype wire

// File: rtl/udiv_seq.sv
// ============================================================================
//  Module   : udiv_seq
//  Purpose  : Multi-cycle unsigned restoring divider, one quotient bit per
//             clock, with a start/busy/done handshake. Divide-by-zero
//             returns an all-ones quotient, remainder = dividend and raises
//             div_zero. Results hold until the next accepted start.
//  Ports    : clock    in   rising-edge clock
//             reset_n  in   asynchronous active-low reset
//             start    in   request, sampled only while busy = 0
//             a, b     in   WIDTH dividend / divisor, sampled with start
//             busy     out  high in RUN and DONE
//             done     out  one-cycle pulse, results valid
//             out, rem out  WIDTH quotient / remainder
//             div_zero out  set with done when b was 0, held with results
//  Config   : UDIV_SEQ_EARLY_EXIT_EN - when defined, a < b (b != 0)
//             completes in one cycle with out = 0, rem = a.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module udiv_seq
  import udiv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [31:0]      ONES_32  = all_ones(WIDTH);
  localparam logic [WIDTH-1:0] ONES     = ONES_32[WIDTH-1:0];
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_next;

  // Working registers, kept apart from the visible results so the previous
  // out/rem stay stable while a new division is running.
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] q_work;
  logic [WIDTH-1:0] b_lat;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;

  logic             b_is_zero;
  logic             early_exit;

  assign b_is_zero = (b == '0);

`ifdef UDIV_SEQ_EARLY_EXIT_EN
  // Quotient is zero and the remainder is the dividend: no steps needed.
  assign early_exit = !b_is_zero && (a < b);
`else
  assign early_exit = 1'b0;
`endif

  udiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r      (r_work),
    .q      (q_work),
    .b      (b_lat),
    .r_next (r_step),
    .q_next (q_step)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (b_is_zero || early_exit) ? DONE : RUN;
        end
      end
      RUN: begin
        if (count == '0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:  busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath. Visible results are loaded on the transition into DONE so they
  // are already valid in the cycle done is high.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_work   <= '0;
      q_work   <= '0;
      b_lat    <= '0;
      count    <= '0;
      out      <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            b_lat <= b;
            if (b_is_zero) begin
              out      <= ONES;
              rem      <= a;
              div_zero <= 1'b1;
            end else if (early_exit) begin
              out      <= '0;
              rem      <= a;
              div_zero <= 1'b0;
            end else begin
              r_work <= '0;
              q_work <= a;
              count  <= CNT_INIT;
            end
          end
        end
        RUN: begin
          r_work <= r_step;
          q_work <= q_step;
          if (count == '0) begin
            out      <= q_step;
            rem      <= r_step;
            div_zero <= 1'b0;
          end else begin
            count <= count - CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : udiv_seq

`default_nettype wire

// File: doc/udiv_seq.md
Name: udiv_seq

Overview:
- Parametrised multi-cycle unsigned divider; successor to the 2-bit combinational divider.
- Computes quotient and remainder of WIDTH-bit operands using restoring division, one quotient bit per cycle.
- Uses a start/done handshake so datapath and control blocks can issue divides without a combinational critical path.
- Divide-by-zero keeps the team rule: quotient all ones.

Parameters:
WIDTH, 8, operand/quotient/remainder width in bits; legal range 2..32.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  dividend, sampled with start
b  input  WIDTH  divisor, sampled with start
busy  output  1  high from accepted start until the cycle after done
done  output  1  one-cycle pulse; results valid
out  output  WIDTH  quotient
rem  output  WIDTH  remainder
div_zero  output  1  set with done when b was 0; held with results

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE.
  - busy=0, done=0, out=0, rem=0, div_zero=0.
  - Internal counter and registers cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → latch a and b.
  - If b==0: go to DONE; load out=all ones, rem=a, div_zero=1.
  - Else: go to RUN; partial remainder R=0, quotient Q=a, count=WIDTH-1.
- RUN, one step per cycle:
  - T={R,Q[WIDTH-1]} (WIDTH+1 bits).
  - If T>=b: R=T-b and shift 1 into Q[0]; else R=T[WIDTH-1:0] and shift 0.
  - count==0 → DONE; else count decrements.
- DONE (one cycle):
  - done=1; out=Q, rem=R, div_zero=0 (b≠0 case).
  - Next state IDLE.
- Latency, counted from the clock edge that samples start:
  - b≠0: done high in cycle WIDTH+1 (WIDTH RUN cycles plus 1 DONE cycle).
  - b==0: done high in cycle 1.
- busy=1 in RUN and DONE.
  - start while busy is ignored; no queueing, latched operands unchanged.
  - Next start is accepted in the cycle after done.
- out, rem and div_zero hold their values after done until the next accepted start.
  - During RUN they keep the previous results; internal working registers are separate.
- Arithmetic:
  - Compare and subtract are WIDTH+1 bits wide; no overflow is possible.
  - Invariant at done: a == out*b + rem and rem < b (b≠0).
- reset_n asserted mid-RUN aborts the operation immediately; no done is produced.
- a or b changing during RUN has no effect.

Optional Feature:
Macro: UDIV_SEQ_EARLY_EXIT_EN.
- Defined: in IDLE with b≠0 and a<b, skip RUN.
  - Go directly to DONE with out=0, rem=a; latency is 1 cycle.
  - Quotient-bit computation is otherwise unchanged.
- Undefined: all b≠0 operations take WIDTH+1 cycles. Results are identical either way; only latency differs.

Decomposition:
- Shared package udiv_pkg: state enum (IDLE, RUN, DONE), localparam for the counter width ($clog2(WIDTH)), and a function giving the all-ones constant for a width.
- Sub-module udiv_step: combinational single restoring step.
  - Inputs: R, Q, b. Outputs: next R, next Q.
  - Instantiated once in udiv_seq.

Test Plan:
1. WIDTH=8, a=100, b=7, start pulse:
   - done in exactly cycle 9; out=14, rem=2, div_zero=0.
   - busy high in cycles 1-9.
2. WIDTH=8, a=5, b=0:
   - done in cycle 1; out=255, rem=5, div_zero=1.
   - Outputs held until the next start.
3. WIDTH=8, a=255, b=1, then start re-pulsed with a=9, b=3 in cycle 4:
   - Second request ignored; out=255, rem=0 at cycle 9.
   - A new start in cycle 10 then gives out=3, rem=0.
4. WIDTH=8, a=200, b=13: drop reset_n in cycle 5.
   - All outputs 0 immediately; no done pulse.
   - After release, a=200, b=13 gives out=15, rem=5.
5. WIDTH=2, all 16 a/b pairs (e.g. 3/2→1 r1, 2/0→3 r2, 1/3→0 r1):
   - Quotient matches the 2-bit combinational divider; done in cycle 3, or cycle 1 when b=0.
6. UDIV_SEQ_EARLY_EXIT_EN defined, WIDTH=8, a=3, b=10:
   - done in cycle 1; out=0, rem=3.
   - Without the macro: same results, done in cycle 9.
